// File: rtl/scan_pkg.sv
// Shared constants for the scanned 7-segment display: digit slots and abcdefg
// segment patterns (bit 6 = a, active-high).
package scan_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [2:0] slot_idx_t;

  localparam int NUM_DIGITS = 6;

  localparam slot_idx_t IDX_SEC_U = 3'd0;
  localparam slot_idx_t IDX_SEC_T = 3'd1;
  localparam slot_idx_t IDX_MIN_U = 3'd2;
  localparam slot_idx_t IDX_MIN_T = 3'd3;
  localparam slot_idx_t IDX_HR_U  = 3'd4;
  localparam slot_idx_t IDX_HR_T  = 3'd5;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to abcdefg decoder; non-decimal codes (10-15) are
// blanked rather than shown as hex glyphs.
module bcd_to_seg7
  import scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/scan_display_mux.sv
// Six-digit time-multiplexed 7-segment driver with a per-frame input snapshot.
// Optional SCAN_LEADING_ZERO_BLANK_EN blanks the hours-tens digit when it is 0.
module scan_display_mux
  import scan_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] sec_u,
  input  logic [3:0] sec_t,
  input  logic [3:0] min_u,
  input  logic [3:0] min_t,
  input  logic [3:0] hr_u,
  input  logic [3:0] hr_t,
  output logic [6:0] seg,
  output logic [5:0] dig_sel,
  output logic       frame_done
);

  logic [CNT_W-1:0] div_cnt;
  logic             tick;
  slot_idx_t        idx;
  slot_idx_t        idx_next;
  logic             wrap;
  bcd_t             shadow [NUM_DIGITS];
  bcd_t             dec_in;
  logic [6:0]       dec_out;
  logic [6:0]       seg_next;

  assign tick = (div_cnt == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)      div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  always_comb begin
    idx_next = idx;
    wrap     = 1'b0;
    if (tick) begin
      if (idx == IDX_HR_T) begin
        idx_next = IDX_SEC_U;
        wrap     = 1'b1;
      end else begin
        idx_next = idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) idx <= IDX_SEC_U;
    else      idx <= idx_next;
  end

  // The whole frame is latched in one edge so a frame never mixes two counts.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
    end else if (wrap) begin
      shadow[0] <= sec_u;
      shadow[1] <= sec_t;
      shadow[2] <= min_u;
      shadow[3] <= min_t;
      shadow[4] <= hr_u;
      shadow[5] <= hr_t;
    end
  end

  // On the wrap edge the shadow is still stale, so slot 0 bypasses it.
  always_comb begin
    dec_in = shadow[0];
    case (idx_next)
      IDX_SEC_T: dec_in = shadow[1];
      IDX_MIN_U: dec_in = shadow[2];
      IDX_MIN_T: dec_in = shadow[3];
      IDX_HR_U:  dec_in = shadow[4];
      IDX_HR_T:  dec_in = shadow[5];
      default:   dec_in = shadow[0];
    endcase
    if (wrap) dec_in = sec_u;
  end

  bcd_to_seg7 u_dec (
    .bcd (dec_in),
    .seg (dec_out)
  );

`ifdef SCAN_LEADING_ZERO_BLANK_EN
  assign seg_next = (idx_next == IDX_HR_T && shadow[5] == 4'd0) ? SEG_BLANK : dec_out;
`else
  assign seg_next = dec_out;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      dig_sel    <= 6'b000001;
      seg        <= SEG_0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (tick) begin
        dig_sel <= 6'b000001 << idx_next;
        seg     <= seg_next;
      end
    end
  end

endmodule
